wb_write_arbiter: RTL and testbench



---
 rtl/wb_write_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: owns the single register-file write port and merges two sources into it.
//   - In-order pipeline writeback (pipe_*). It is never held off and always has priority.
//   - Late mult/div results (long_*). They arrive on a valid/ready handshake and wait in a
//     DEPTH-entry FIFO until the port is free.
// An effective pipeline write kills any older buffered entry with the same destination (WAW).
// A buffer head that waits too long raises stall_req for one cycle, so the head can drain.
// q_hit1/q_hit2 report pending live destinations to the ID-stage interlock.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pipe_we/pipe_waddr/pipe_wdata    pipeline write request
//   long_valid/long_waddr/long_wdata late result offer; long_ready = buffer not full
//   rf_we/rf_waddr/rf_wdata          registered register-file write port
//   stall_req                        registered one-cycle upstream freeze request
//   q_addr1/q_addr2 -> q_hit1/q_hit2 combinational pending-destination lookup
//
// Optional feature macro: WB_BYPASS_EN. When it is defined, a late result offered while the
// buffer is empty and the port is idle goes straight to rf_* at the next edge.
module wb_write_arbiter #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              long_valid,
  input  logic [ADDR_W-1:0] long_waddr,
  input  logic [DATA_W-1:0] long_wdata,
  output logic              long_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_hit1,
  output logic              q_hit2
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [ADDR_W-1:0]  addr_d [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               rf_we_q, rf_we_d, stall_q, stall_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  logic pipe_eff, empty, full, bypass, push, pop;

  always_comb begin
    pipe_eff   = pipe_we && (pipe_waddr != '0);
    empty      = (count_q == '0);
    full       = (count_q == CntW'(DEPTH));
    long_ready = !rst && !full;
`ifdef WB_BYPASS_EN
    bypass     = long_valid && long_ready && empty && !pipe_eff && (long_waddr != '0);
`else
    bypass     = 1'b0;
`endif
    // Zero-destination late results complete the handshake but are never stored.
    push       = long_valid && long_ready && (long_waddr != '0) && !bypass;
    pop        = !pipe_eff && !empty;
  end

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    live_d     = live_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    starve_d   = starve_q;
    stall_d    = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = '0;

    // WAW kill against entries already buffered; a same-cycle push is younger and is set below.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pipe_eff && live_q[i] && (addr_q[i] == pipe_waddr)) live_d[i] = 1'b0;
    end

    // Live bits are cleared on pop, so any set bit is inside the occupied region.
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PtrW'(1);
    end

    // Never aliases the popped slot: that would need a full buffer, where long_ready is low.
    if (push) begin
      addr_d[wr_ptr_q] = long_waddr;
      data_d[wr_ptr_q] = long_wdata;
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // Saturate so a stall_req ignored by upstream is not re-raised by counter wrap.
    if (pop || empty) begin
      starve_d = '0;
    end else if (starve_q != StarveW'(STARVE_LIMIT)) begin
      starve_d = starve_q + StarveW'(1);
    end
    stall_d = !empty && !pop && (starve_q == StarveW'(STARVE_LIMIT - 1));

    if (pipe_eff) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = pipe_waddr;
      rf_wdata_d = pipe_wdata;
    end else if (pop) begin
      // A killed head still pops, just without a write.
      rf_we_d    = live_q[rd_ptr_q];
      rf_waddr_d = addr_q[rd_ptr_q];
      rf_wdata_d = data_q[rd_ptr_q];
    end else if (bypass) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = long_waddr;
      rf_wdata_d = long_wdata;
    end
  end

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == q_addr1)) q_hit1 = 1'b1;
      if (live_q[i] && (addr_q[i] == q_addr2)) q_hit2 = 1'b1;
    end
    if (rst || (q_addr1 == '0)) q_hit1 = 1'b0;
    if (rst || (q_addr2 == '0)) q_hit2 = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      live_q     <= live_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter. A queue-based reference of the late-result buffer
// predicts each cycle's combinational outputs and the registered rf_*/stall_req values that
// follow; the predictions go through a scoreboard queue and are compared after the edge.
module tb_wb_write_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk, rst;
  logic              pipe_we, long_valid, long_ready;
  logic [ADDR_W-1:0] pipe_waddr, long_waddr, rf_waddr, q_addr1, q_addr2;
  logic [DATA_W-1:0] pipe_wdata, long_wdata, rf_wdata;
  logic              rf_we, stall_req, q_hit1, q_hit2;

  wb_write_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .long_valid(long_valid),
    .long_waddr(long_waddr),
    .long_wdata(long_wdata),
    .long_ready(long_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_req (stall_req),
    .q_addr1   (q_addr1),
    .q_addr2   (q_addr2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              live;
  } ent_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              st;
    logic              rst_cyc;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   mcnt;
  int   total = 0;
  int   bad = 0;
  int   stall_seen = 0;
  int   rf_writes = 0;
  bit   m_stall = 0;
  bit   xf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Inputs must already be driven; advances one clock and checks everything for that cycle.
  task automatic cycle(output bit xfer);
    bit   pe, pop, byp, ready, h1, h2, was_empty;
    exp_t e;
    ent_t t;
    #1;
    e = '0;
    xfer = 0;
    if (rst) begin
      ready = 0; h1 = 0; h2 = 0;
      e.rst_cyc = 1;
      mq.delete();
      mcnt = 0;
    end else begin
      pe    = pipe_we && (pipe_waddr != 0);
      ready = (mq.size() < DEPTH);
      xfer  = long_valid && ready;
      byp   = 0;
`ifdef WB_BYPASS_EN
      byp   = long_valid && (mq.size() == 0) && !pe && (long_waddr != 0);
`endif
      pop   = !pe && (mq.size() != 0);
      h1 = 0; h2 = 0;
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].live && mq[i].a == q_addr1 && q_addr1 != 0) h1 = 1;
        if (mq[i].live && mq[i].a == q_addr2 && q_addr2 != 0) h2 = 1;
      end
      e.st = (mq.size() != 0) && !pop && (mcnt == STARVE_LIMIT - 1);
      if (pe) begin
        e.we = 1; e.a = pipe_waddr; e.d = pipe_wdata;
      end else if (pop) begin
        e.we = mq[0].live; e.a = mq[0].a; e.d = mq[0].d;
      end else if (byp) begin
        e.we = 1; e.a = long_waddr; e.d = long_wdata;
      end
      if (pe) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].a == pipe_waddr) begin
            t = mq[i]; t.live = 0; mq[i] = t;
          end
        end
      end
      was_empty = (mq.size() == 0);
      if (pop || was_empty) mcnt = 0;
      else if (mcnt < STARVE_LIMIT) mcnt++;
      if (pop) void'(mq.pop_front());
      if (xfer && long_waddr != 0 && !byp) begin
        t.a = long_waddr; t.d = long_wdata; t.live = 1;
        mq.push_back(t);
      end
    end
    check_eq("long_ready", {63'd0, long_ready}, {63'd0, ready});
    check_eq("q_hit1", {63'd0, q_hit1}, {63'd0, h1});
    check_eq("q_hit2", {63'd0, q_hit2}, {63'd0, h2});
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("rf_we", {63'd0, rf_we}, {63'd0, e.we});
    if (e.we || e.rst_cyc) begin
      check_eq("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.a});
      check_eq("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.d});
    end
    check_eq("stall_req", {63'd0, stall_req}, {63'd0, e.st});
    m_stall = e.st;
    if (stall_req) stall_seen++;
    if (rf_we) rf_writes++;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
    long_valid = 0; long_waddr = 0; long_wdata = 0;
    q_addr1 = 0; q_addr2 = 0;
  endtask

  initial begin
    int k, n;
    idle_inputs();
    // Reset held three cycles with active requests on both sources.
    rst = 1;
    pipe_we = 1; pipe_waddr = 5; pipe_wdata = 32'h1111;
    long_valid = 1; long_waddr = 7; long_wdata = 32'h2222;
    q_addr1 = 7; q_addr2 = 5;
    repeat (3) cycle(xf);
    rst = 0;
    idle_inputs();
    cycle(xf);

    // Pipeline only.
    pipe_we = 1; pipe_waddr = 5; pipe_wdata = 32'hDEADBEEF;
    cycle(xf);
    pipe_waddr = 0; pipe_wdata = 32'hCAFEF00D;
    cycle(xf);
    idle_inputs();
    cycle(xf);

    // Late result with an idle pipe; the buffered entry is visible to q_addr1.
    long_valid = 1; long_waddr = 7; long_wdata = 32'h12345678; q_addr1 = 7;
    cycle(xf);
    long_valid = 0;
    repeat (3) cycle(xf);
    idle_inputs();

    // Fill the buffer behind a busy pipe until starvation forces a stall.
    stall_seen = 0;
    for (int i = 0; i < 5; i++) begin
      pipe_we = 1; pipe_waddr = ADDR_W'(20 + i); pipe_wdata = 32'h100 + i;
      long_valid = (i < 2);
      long_waddr = (i == 0) ? 5'd3 : 5'd4;
      long_wdata = (i == 0) ? 32'hA : 32'hB;
      cycle(xf);
    end
    idle_inputs();
    repeat (3) cycle(xf);
    check_eq("stall_cycles", 64'(stall_seen), 64'd1);

    // WAW kill: the buffered reg 9 is overwritten by a younger pipeline write.
    pipe_we = 1; pipe_waddr = 10; pipe_wdata = 32'h55;
    long_valid = 1; long_waddr = 9; long_wdata = 32'h1; q_addr2 = 9;
    cycle(xf);
    long_valid = 0; pipe_waddr = 9; pipe_wdata = 32'h2;
    cycle(xf);
    pipe_we = 0;
    repeat (2) cycle(xf);
    idle_inputs();

    // Six late results with intermittent pipeline writes, enough to wrap the pointers.
    k = 0; n = 0;
    rf_writes = 0;
    while (k < 6 && n < 40) begin
      long_valid = 1; long_waddr = ADDR_W'(11 + k); long_wdata = 32'hC0DE0000 + k;
      pipe_we = (n % 3 != 0) && !m_stall; pipe_waddr = 25; pipe_wdata = n;
      q_addr1 = ADDR_W'(11 + k);
      cycle(xf);
      if (xf) k++;
      n++;
    end
    check_eq("wrap_accepted", 64'(k), 64'd6);
    idle_inputs();
    repeat (6) cycle(xf);

    // Random traffic with occasional mid-operation reset; upstream honours stall_req.
    for (int i = 0; i < 300; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      pipe_we    = m_stall ? 1'b0 : 1'($urandom_range(0, 1));
      pipe_waddr = ADDR_W'($urandom_range(0, 7));
      pipe_wdata = $urandom;
      long_valid = 1'($urandom_range(0, 1));
      long_waddr = ADDR_W'($urandom_range(0, 7));
      long_wdata = $urandom;
      q_addr1    = ADDR_W'($urandom_range(0, 7));
      q_addr2    = ADDR_W'($urandom_range(0, 7));
      cycle(xf);
    end
    rst = 0;
    idle_inputs();
    repeat (6) cycle(xf);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
